// File: rtl/sw_debounce_pkg.sv
// sw_debounce shared types and defaults.
// Board-level switch conditioner package.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, stability counter,
// debounce FSM and registered rise/fall pulses.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int          NB_COUNTER      = 32,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall,
  output logic o_change
);

  localparam logic [NB_COUNTER-1:0] LAST =
    NB_COUNTER'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_COUNTER-1:0] ONE = NB_COUNTER'(1);

  logic                  s1;
  logic                  s2;
  state_t                state;
  state_t                state_nxt;
  logic [NB_COUNTER-1:0] cnt;
  logic [NB_COUNTER-1:0] cnt_nxt;
  logic                  rise_nxt;
  logic                  fall_nxt;

  // cnt holds how many sampled edges already showed the new level
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (s2) begin
          if (LAST == '0) begin
            state_nxt = STABLE_HI;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_HI;
            cnt_nxt   = ONE;
          end
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          if (LAST == '0) begin
            state_nxt = STABLE_LO;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_LO;
            cnt_nxt   = ONE;
          end
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      state  <= STABLE_LO;
      cnt    <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      s1     <= i_sw;
      s2     <= s1;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      o_rise <= rise_nxt;
      o_fall <= fall_nxt;
    end
  end

  assign o_sw     = (state == STABLE_HI) || (state == WAIT_LO);
  assign o_change = rise_nxt | fall_nxt;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioner: per-bit debouncers plus a shared
// registered change strobe.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int          NB_SW           = 4,
  parameter int          NB_COUNTER      = 32,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_rise,
  output logic [NB_SW-1:0] o_fall,
  output logic             o_valid
);

  logic [NB_SW-1:0] change;

  for (genvar i = 0; i < NB_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .NB_COUNTER     (NB_COUNTER),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock   (clock),
      .i_reset (i_reset),
      .i_sw    (i_sw[i]),
      .o_sw    (o_sw[i]),
      .o_rise  (o_rise[i]),
      .o_fall  (o_fall[i]),
      .o_change(change[i])
    );
  end

  // Registered from the same next-state terms as the pulses
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) o_valid <= 1'b0;
    else          o_valid <= |change;
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed plan items
// plus randomized toggling against a history-based model.
module tb_sw_debounce;

  localparam int NB = 4;
  localparam int D  = 4;

  logic          clock;
  logic          i_reset;
  logic [NB-1:0] i_sw;
  logic [NB-1:0] o_sw;
  logic [NB-1:0] o_rise;
  logic [NB-1:0] o_fall;
  logic          o_valid;

  int n_checks = 0;
  int n_errors = 0;

  sw_debounce #(
    .NB_SW          (NB),
    .NB_COUNTER     (32),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .i_sw   (i_sw),
    .o_sw   (o_sw),
    .o_rise (o_rise),
    .o_fall (o_fall),
    .o_valid(o_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: a level is accepted once the last D synchronised samples
  // all differ from the current output.
  logic [NB-1:0] cap[$];
  logic [NB-1:0] exp_sw;
  logic [NB-1:0] exp_rise;
  logic [NB-1:0] exp_fall;
  logic          exp_valid;
  logic          all_new;
  int            n;

  function automatic logic seen(int e, int b);
    if (e >= 3) return cap[e-3][b];
    return 1'b0;
  endfunction

  always @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      cap.delete();
      exp_sw    = '0;
      exp_rise  = '0;
      exp_fall  = '0;
      exp_valid = 1'b0;
    end else begin
      cap.push_back(i_sw);
      n        = cap.size();
      exp_rise = '0;
      exp_fall = '0;
      for (int b = 0; b < NB; b++) begin
        all_new = 1'b1;
        for (int e = n - D + 1; e <= n; e++)
          if (seen(e, b) == exp_sw[b]) all_new = 1'b0;
        if (all_new) begin
          exp_sw[b] = ~exp_sw[b];
          if (exp_sw[b]) exp_rise[b] = 1'b1;
          else           exp_fall[b] = 1'b1;
        end
      end
      exp_valid = |(exp_rise | exp_fall);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    chk("m_sw", 32'(o_sw), 32'(exp_sw));
    chk("m_rise", 32'(o_rise), 32'(exp_rise));
    chk("m_fall", 32'(o_fall), 32'(exp_fall));
    chk("m_valid", 32'(o_valid), 32'(exp_valid));
  endtask

  task automatic measure(input logic [NB-1:0] tgt, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (o_sw !== tgt && lat < 40);
  endtask

  task automatic settle(input int cyc, output int pulses);
    pulses = 0;
    repeat (cyc) begin
      tick();
      if (o_valid) pulses++;
    end
  endtask

  int lat;
  int pulses;
  logic [5:0] bounce;

  initial begin
    i_reset = 1'b0;
    i_sw    = 4'b1010;
    repeat (10) tick();
    chk("rst_sw", 32'(o_sw), 32'h0);
    chk("rst_pulse", 32'({o_rise, o_fall, o_valid}), 32'h0);

    i_reset = 1'b1;
    measure(4'b1010, lat);
    chk("rst_lat", lat, D + 2);
    chk("rst_rise", 32'(o_rise), 32'hA);
    chk("rst_valid", 32'(o_valid), 32'h1);
    tick();
    chk("rst_rise_end", 32'(o_rise), 32'h0);

    i_sw = 4'b0000;
    measure(4'b0000, lat);
    chk("fall_lat", lat, D + 2);
    chk("fall_bits", 32'(o_fall), 32'hA);

    i_sw[0] = 1'b1;
    measure(4'b0001, lat);
    chk("clean_lat", lat, D + 2);
    chk("clean_rise", 32'(o_rise), 32'h1);
    settle(3, pulses);
    chk("clean_single", pulses, 0);
    i_sw[0] = 1'b0;
    measure(4'b0000, lat);
    chk("clean_fall_lat", lat, D + 2);
    chk("clean_fall", 32'(o_fall), 32'h1);

    bounce  = 6'b101101;
    pulses  = 0;
    for (int k = 5; k >= 1; k--) begin
      i_sw[1] = bounce[k];
      tick();
      if (o_valid) pulses++;
    end
    chk("bounce_quiet", pulses, 0);
    i_sw[1] = 1'b1;
    measure(4'b0010, lat);
    chk("bounce_lat", lat, D + 2);

    i_sw = 4'b0000;
    settle(12, pulses);
    i_sw[2] = 1'b1;
    repeat (3) tick();
    i_sw[2] = 1'b0;
    settle(12, pulses);
    chk("glitch_pulses", pulses, 0);
    chk("glitch_sw", 32'(o_sw), 32'h0);

    i_sw = 4'b1111;
    measure(4'b1111, lat);
    chk("simul_lat", lat, D + 2);
    chk("simul_rise", 32'(o_rise), 32'hF);
    chk("simul_valid", 32'(o_valid), 32'h1);
    settle(10, pulses);
    chk("simul_single", pulses, 0);

    i_sw = 4'b0111;
    settle(12, pulses);
    i_sw[3] = 1'b1;
    repeat (2) tick();
    #1 i_reset = 1'b0;
    #1 chk("mid_rst_sw", 32'(o_sw), 32'h0);
    chk("mid_rst_pulse", 32'({o_rise, o_fall, o_valid}), 32'h0);
    repeat (3) tick();
    i_reset = 1'b1;
    pulses  = 0;
    lat     = 0;
    do begin
      tick();
      lat++;
      if (o_valid && o_sw !== 4'b1111) pulses++;
    end while (o_sw !== 4'b1111 && lat < 40);
    chk("mid_rst_lat", lat, D + 2);
    chk("mid_rst_early", pulses, 0);

    for (int seg = 0; seg < 300; seg++) begin
      int mode;
      int len;
      mode = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 12));
      for (int c = 0; c < len; c++) begin
        if (mode == 1 && $urandom_range(0, 1) == 1)
          i_sw[$urandom_range(0, NB - 1)] ^= 1'b1;
        else if (mode == 2)
          i_sw = NB'($urandom);
        tick();
      end
      if (mode == 3 && $urandom_range(0, 9) == 0) begin
        #1 i_reset = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        i_reset = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
